// File: rtl/traffic_phase_controller.sv
// Traffic phase controller: green/yellow/all-red sequencing for N
// conflicting approaches with demand skip, gap-out and emergency preemption.
module traffic_phase_controller #(
    parameter int N_PHASES  = 4,
    parameter int PW        = 2,
    parameter int TW        = 5,
    parameter int GREEN_T   = 20,
    parameter int MIN_GREEN = 6,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [N_PHASES-1:0] VEH_REQ,
    input  logic                EMERG,
    input  logic [PW-1:0]       EMERG_PHASE,
    output logic [N_PHASES-1:0] RED,
    output logic [N_PHASES-1:0] YELLOW,
    output logic [N_PHASES-1:0] GREEN,
    output logic [PW-1:0]       ACTIVE_PHASE,
    output logic                PREEMPT_ACT,
    output logic [TW-1:0]       timer
);

    typedef enum logic [1:0] {
        S_ALL_RED,
        S_GREEN,
        S_YELLOW,
        S_PREEMPT
    } state_e;

    localparam logic [TW-1:0] GREEN_LD  = TW'(GREEN_T - 1);
    localparam logic [TW-1:0] YELLOW_LD = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] ALLRED_LD = TW'(ALLRED_T - 1);
    localparam int            GAP_I     = GREEN_T - MIN_GREEN;
    localparam bit            GAP_EN    = (GAP_I >= 0);
    localparam logic [TW-1:0] GAP_LD    = TW'(GAP_I);
    localparam logic [PW-1:0] LAST_PH   = PW'(N_PHASES - 1);
    localparam logic [PW:0]   N_EXT     = (PW+1)'(N_PHASES);
    localparam logic [N_PHASES-1:0] PH_ONE =
        {{(N_PHASES-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [N_PHASES-1:0] red_q, red_d;
    logic [N_PHASES-1:0] yellow_q, yellow_d;
    logic [N_PHASES-1:0] green_q, green_d;
    logic                preempt_q, preempt_d;

    logic                emerg_ok;
    logic [N_PHASES-1:0] active_mask;
    logic                own_req;
    logic                other_req;
    logic                gap_ok;
    logic [PW-1:0]       phase_inc;
    logic [PW-1:0]       pick;
    logic [PW-1:0]       cand;
    logic                found;
    logic [N_PHASES-1:0] lamp_mask;

    // Qualify the preemption request and summarise demand around the active phase
    always_comb begin
        emerg_ok    = EMERG && ({1'b0, EMERG_PHASE} < N_EXT);
        active_mask = PH_ONE << phase_q;
        own_req     = |(VEH_REQ & active_mask);
        other_req   = |(VEH_REQ & ~active_mask);
        gap_ok      = GAP_EN && (timer_q <= GAP_LD);
        phase_inc   = (phase_q == LAST_PH) ? '0 : phase_q + PW'(1);
    end

    // Cyclic demand search starting after the active phase, active phase last
    always_comb begin
        found = 1'b0;
        pick  = phase_inc;
        cand  = '0;
        for (int k = 1; k <= N_PHASES; k++) begin
            cand = PW'((int'(phase_q) + k) % N_PHASES);
            if (!found && |(VEH_REQ & (PH_ONE << cand))) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next state, timer and served phase
    always_comb begin
        state_d = state_q;
        timer_d = timer_q - TW'(1);
        phase_d = phase_q;
        unique case (state_q)
            S_ALL_RED: begin
                if (timer_q == '0) begin
                    if (emerg_ok) begin
                        state_d = S_PREEMPT;
                        phase_d = EMERG_PHASE;
                        timer_d = '0;
                    end else begin
                        state_d = S_GREEN;
                        phase_d = pick;
                        timer_d = GREEN_LD;
                    end
                end
            end
            S_GREEN: begin
                if (emerg_ok && (EMERG_PHASE != phase_q)) begin
                    state_d = S_YELLOW;
                    timer_d = YELLOW_LD;
                end else if (emerg_ok) begin
                    state_d = S_PREEMPT;
                    timer_d = '0;
                end else if ((timer_q == '0) ||
                             (gap_ok && !own_req && other_req)) begin
                    state_d = S_YELLOW;
                    timer_d = YELLOW_LD;
                end
            end
            S_YELLOW: begin
                if (timer_q == '0) begin
                    state_d = S_ALL_RED;
                    timer_d = ALLRED_LD;
                end
            end
            S_PREEMPT: begin
                timer_d = '0;
                if (!emerg_ok) begin
                    state_d = S_YELLOW;
                    timer_d = YELLOW_LD;
                end
            end
        endcase
    end

    // Lamp pattern for the upcoming cycle, so lamps leave a flop
    always_comb begin
        red_d     = '1;
        yellow_d  = '0;
        green_d   = '0;
        lamp_mask = PH_ONE << phase_d;
        preempt_d = (state_d == S_PREEMPT);
        unique case (state_d)
            S_GREEN, S_PREEMPT: begin
                green_d = lamp_mask;
                red_d   = ~lamp_mask;
            end
            S_YELLOW: begin
                yellow_d = lamp_mask;
                red_d    = ~lamp_mask;
            end
            S_ALL_RED: begin
                red_d = '1;
            end
        endcase
    end

    // State and output registers; reset parks on the last phase in all-red
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_ALL_RED;
            timer_q   <= ALLRED_LD;
            phase_q   <= LAST_PH;
            red_q     <= '1;
            yellow_q  <= '0;
            green_q   <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            phase_q   <= phase_d;
            red_q     <= red_d;
            yellow_q  <= yellow_d;
            green_q   <= green_d;
            preempt_q <= preempt_d;
        end
    end

    assign RED          = red_q;
    assign YELLOW       = yellow_q;
    assign GREEN        = green_q;
    assign ACTIVE_PHASE = phase_q;
    assign PREEMPT_ACT  = preempt_q;
    assign timer        = timer_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: a 4-phase and a 3-phase instance
// checked every cycle against a segment-level model plus literal checkpoints.
module tb_traffic_phase_controller;

    localparam int GT = 20;
    localparam int MG = 6;
    localparam int YT = 4;
    localparam int AT = 2;

    localparam int SEG_AR = 0;
    localparam int SEG_G  = 1;
    localparam int SEG_Y  = 2;
    localparam int SEG_P  = 3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] veh = '0;
    logic       emerg = 1'b0;
    logic [1:0] ephase = '0;

    logic [3:0] red4, yel4, grn4;
    logic [1:0] act4;
    logic       pre4;
    logic [4:0] tmr4;

    logic [2:0] red3, yel3, grn3;
    logic [1:0] act3;
    logic       pre3;
    logic [4:0] tmr3;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int seg [2];
    int el  [2];
    int ph  [2];
    int np  [2] = '{4, 3};

    traffic_phase_controller #(
        .N_PHASES(4), .PW(2), .TW(5), .GREEN_T(GT),
        .MIN_GREEN(MG), .YELLOW_T(YT), .ALLRED_T(AT)
    ) dut4 (
        .CLK(CLK), .RESET(RESET), .VEH_REQ(veh), .EMERG(emerg),
        .EMERG_PHASE(ephase), .RED(red4), .YELLOW(yel4), .GREEN(grn4),
        .ACTIVE_PHASE(act4), .PREEMPT_ACT(pre4), .timer(tmr4)
    );

    traffic_phase_controller #(
        .N_PHASES(3), .PW(2), .TW(5), .GREEN_T(GT),
        .MIN_GREEN(MG), .YELLOW_T(YT), .ALLRED_T(AT)
    ) dut3 (
        .CLK(CLK), .RESET(RESET), .VEH_REQ(veh[2:0]), .EMERG(emerg),
        .EMERG_PHASE(ephase), .RED(red3), .YELLOW(yel3), .GREEN(grn3),
        .ACTIVE_PHASE(act3), .PREEMPT_ACT(pre3), .timer(tmr3)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic int dur(input int s);
        case (s)
            SEG_AR:  return AT;
            SEG_G:   return GT;
            SEG_Y:   return YT;
            default: return 1;
        endcase
    endfunction

    task automatic m_reset(input int i);
        seg[i] = SEG_AR;
        el[i]  = 0;
        ph[i]  = np[i] - 1;
    endtask

    function automatic bit req(input logic [3:0] v, input int p);
        return ((v >> p) & 4'd1) != 4'd0;
    endfunction

    task automatic go(input int i, input int s);
        seg[i] = s;
        el[i]  = 0;
    endtask

    // One clock of the model: n is how many cycles the segment has been shown
    task automatic m_step(input int i, input logic [3:0] v, input logic e,
                          input logic [1:0] ep);
        int  n;
        int  nxt;
        bit  ev;
        bit  other;
        bit  hit;
        n     = el[i] + 1;
        ev    = e && (int'(ep) < np[i]);
        other = 1'b0;
        for (int p = 0; p < np[i]; p++)
            if (p != ph[i] && req(v, p)) other = 1'b1;
        case (seg[i])
            SEG_AR: begin
                if (n == AT) begin
                    if (ev) begin
                        ph[i] = int'(ep);
                        go(i, SEG_P);
                    end else begin
                        nxt = (ph[i] + 1) % np[i];
                        hit = 1'b0;
                        for (int k = 1; k <= np[i]; k++)
                            if (!hit && req(v, (ph[i] + k) % np[i])) begin
                                hit = 1'b1;
                                nxt = (ph[i] + k) % np[i];
                            end
                        ph[i] = nxt;
                        go(i, SEG_G);
                    end
                end else el[i] = n;
            end
            SEG_G: begin
                if (ev && int'(ep) != ph[i]) go(i, SEG_Y);
                else if (ev) go(i, SEG_P);
                else if (n == GT || (n >= MG && !req(v, ph[i]) && other))
                    go(i, SEG_Y);
                else el[i] = n;
            end
            SEG_Y: begin
                if (n == YT) go(i, SEG_AR);
                else el[i] = n;
            end
            default: begin
                if (!ev) go(i, SEG_Y);
            end
        endcase
    endtask

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_reset(0);
            m_reset(1);
        end else begin
            m_step(0, veh, emerg, ephase);
            m_step(1, {1'b0, veh[2:0]}, emerg, ephase);
        end
    end

    task automatic cmp(input int i, input logic [3:0] r, input logic [3:0] y,
                       input logic [3:0] g, input logic [1:0] a,
                       input logic p, input logic [4:0] t);
        logic [3:0] all;
        logic [3:0] oh;
        int bad;
        string pf;
        pf  = (i == 0) ? "n4" : "n3";
        all = 4'((1 << np[i]) - 1);
        oh  = (seg[i] == SEG_AR) ? 4'd0 : 4'(1 << ph[i]);
        chk({pf, "_red"}, 32'(r), 32'(all & ~oh));
        chk({pf, "_yellow"}, 32'(y), (seg[i] == SEG_Y) ? 32'(oh) : 0);
        chk({pf, "_green"}, 32'(g),
            (seg[i] == SEG_G || seg[i] == SEG_P) ? 32'(oh) : 0);
        chk({pf, "_active"}, 32'(a), 32'(ph[i]));
        chk({pf, "_preempt"}, 32'(p), (seg[i] == SEG_P) ? 1 : 0);
        chk({pf, "_timer"}, 32'(t),
            (seg[i] == SEG_P) ? 0 : 32'(dur(seg[i]) - 1 - el[i]));
        chk({pf, "_onehot_gy"}, 32'($onehot0(g | y)), 1);
        bad = 0;
        for (int q = 0; q < np[i]; q++)
            if ((32'(r[q]) + 32'(y[q]) + 32'(g[q])) != 1) bad++;
        chk({pf, "_one_lamp"}, 32'(bad), 0);
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            cmp(0, red4, yel4, grn4, act4, pre4, tmr4);
            cmp(1, {1'b0, red3}, {1'b0, yel3}, {1'b0, grn3}, act3, pre3,
                tmr3);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #2 RESET = 1'b1;
        #1 chk_en = 1'b1;
        tick(3);
        chk("rst_red", 32'(red4), 32'hF);
        chk("rst_green", 32'(grn4), 0);
        chk("rst_timer", 32'(tmr4), 1);
        chk("rst_active", 32'(act4), 3);
        chk("rst3_active", 32'(act3), 2);
        RESET = 1'b0;

        // fixed-time rotation
        tick(1);
        chk("ft_ar_timer", 32'(tmr4), 0);
        tick(1);
        chk("ft_g0", 32'(grn4), 32'h1);
        chk("ft_g0_timer", 32'(tmr4), 19);
        tick(20);
        chk("ft_y0", 32'(yel4), 32'h1);
        chk("ft_y0_timer", 32'(tmr4), 3);
        tick(4);
        chk("ft_ar_red", 32'(red4), 32'hF);
        tick(2);
        chk("ft_g1", 32'(grn4), 32'h2);
        tick(78);
        chk("ft_g0_again", 32'(grn4), 32'h1);
        chk("ft_g0_again_act", 32'(act4), 0);

        // gap-out after min green
        tick(1);
        veh = 4'b0010;
        tick(4);
        chk("gap_g6", 32'(grn4), 32'h1);
        chk("gap_g6_timer", 32'(tmr4), 14);
        tick(1);
        chk("gap_yellow", 32'(yel4), 32'h1);
        tick(6);
        chk("gap_g1", 32'(grn4), 32'h2);

        // preemption mid-green to phase 3
        tick(2);
        emerg  = 1'b1;
        ephase = 2'd3;
        tick(1);
        chk("pre_yellow", 32'(yel4), 32'h2);
        chk("pre_yellow_timer", 32'(tmr4), 3);
        tick(4);
        chk("pre_allred", 32'(red4), 32'hF);
        tick(2);
        chk("pre_green", 32'(grn4), 32'h8);
        chk("pre_act", 32'(pre4), 1);
        chk("pre_timer", 32'(tmr4), 0);
        chk("pre3_illegal", 32'(pre3), 0);
        tick(49);
        chk("pre_hold", 32'(grn4), 32'h8);
        chk("pre_hold_act", 32'(pre4), 1);
        emerg = 1'b0;
        tick(1);
        chk("pre_exit_y", 32'(yel4), 32'h8);
        chk("pre_exit_act", 32'(pre4), 0);
        tick(6);
        chk("pre_resume", 32'(grn4), 32'h2);

        // demand skip to phase 2 only
        veh = 4'b0100;
        tick(6);
        chk("skip_gap_y", 32'(yel4), 32'h2);
        tick(6);
        chk("skip_g2", 32'(grn4), 32'h4);
        tick(19);
        chk("skip_full", 32'(grn4), 32'h4);
        tick(1);
        chk("skip_y2", 32'(yel4), 32'h4);
        tick(6);
        chk("skip_g2_again", 32'(grn4), 32'h4);

        // asynchronous reset during yellow
        tick(21);
        chk("ry_yellow", 32'(yel4), 32'h4);
        #2;
        veh   = '0;
        RESET = 1'b1;
        #1;
        chk("ry_red", 32'(red4), 32'hF);
        chk("ry_yel", 32'(yel4), 0);
        chk("ry_timer", 32'(tmr4), 1);
        chk("ry_active", 32'(act4), 3);
        tick(1);
        RESET = 1'b0;
        tick(2);
        chk("ry_g0", 32'(grn4), 32'h1);

        // same-phase preemption, later phase change ignored
        emerg  = 1'b1;
        ephase = 2'd0;
        tick(1);
        chk("sp_green", 32'(grn4), 32'h1);
        chk("sp_act", 32'(pre4), 1);
        ephase = 2'd2;
        tick(5);
        chk("sp_keep", 32'(act4), 0);
        chk("sp_keep_g", 32'(grn4), 32'h1);
        emerg = 1'b0;
        tick(1);
        chk("sp_y", 32'(yel4), 32'h1);
        tick(6);
        chk("sp_next", 32'(grn4), 32'h2);

        tick(30);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_phase_controller.md
TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

Interface
- REQ-001: Parameters SHALL be as follows, one per line.
  - N_PHASES, default 4: number of conflicting approaches, legal range 2..8.
  - PW, default 2: phase-index width; N_PHASES <= 2**PW.
  - TW, default 5: timer width.
  - GREEN_T, default 20: maximum green cycles.
  - MIN_GREEN, default 6: minimum green cycles before gap-out.
  - YELLOW_T, default 4: yellow cycles.
  - ALLRED_T, default 2: all-red clearance cycles.
  - All durations SHALL be >= 1 and < 2**TW.
- REQ-002: Ports SHALL be as follows, one per line.
  - CLK, in, 1: single clock, rising edge.
  - RESET, in, 1: asynchronous, active-high reset.
  - VEH_REQ, in, N_PHASES: per-phase demand, level-sensitive.
  - EMERG, in, 1: emergency preemption request.
  - EMERG_PHASE, in, PW: phase to serve during preemption.
  - RED, out, N_PHASES: per-phase red lamp.
  - YELLOW, out, N_PHASES: per-phase yellow lamp.
  - GREEN, out, N_PHASES: per-phase green lamp.
  - ACTIVE_PHASE, out, PW: phase currently or last served.
  - PREEMPT_ACT, out, 1: preemption green in force.
  - timer, out, TW: cycles remaining in the current state.
- REQ-003: All outputs SHALL be registered.

Function
- REQ-004: The FSM SHALL have states ALL_RED, GREEN, YELLOW and PREEMPT.
- REQ-005: Entering a state of duration T SHALL load timer with T-1. Timer SHALL decrement by 1 each cycle. The state SHALL exit on the cycle timer==0, so every state lasts exactly T cycles.
- REQ-006: Lamp encoding:
  - ACTIVE_PHASE SHALL drive exactly one of GREEN, YELLOW or RED as appropriate.
  - Every other phase SHALL drive RED only.
  - In ALL_RED, every phase SHALL drive RED only.
- REQ-007: At most one bit of GREEN|YELLOW SHALL be set in any cycle.
- REQ-008: ALL_RED exit phase selection:
  - If EMERG=1 with a legal EMERG_PHASE, the next phase SHALL be EMERG_PHASE and the state SHALL be PREEMPT.
  - Otherwise, the next phase SHALL be the first phase with VEH_REQ=1, searching cyclically from ACTIVE_PHASE+1 and including ACTIVE_PHASE last.
  - If no request is active, the next phase SHALL be (ACTIVE_PHASE+1) mod N_PHASES and the state SHALL be GREEN (fixed-time fallback).
- REQ-009: GREEN SHALL last GREEN_T cycles, then go to YELLOW.
- REQ-010: Gap-out: once at least MIN_GREEN cycles of green have elapsed, if VEH_REQ[ACTIVE_PHASE]=0 and any other VEH_REQ bit is 1, GREEN SHALL go to YELLOW on the next edge.
- REQ-011: YELLOW SHALL go to ALL_RED after YELLOW_T cycles.
- REQ-012: Preemption during GREEN:
  - If EMERG=1 and EMERG_PHASE != ACTIVE_PHASE, the FSM SHALL go to YELLOW on the next edge, ignoring MIN_GREEN.
  - If EMERG=1 and EMERG_PHASE == ACTIVE_PHASE, the FSM SHALL go to PREEMPT with no lamp change.
- REQ-013: Preemption during YELLOW or ALL_RED: the sequence SHALL complete normally; yellow and clearance times are never shortened.
- REQ-014: In PREEMPT, GREEN[ACTIVE_PHASE]=1 and PREEMPT_ACT=1, and timer SHALL hold at 0. On EMERG falling, the FSM SHALL go to YELLOW.
- REQ-015: EMERG_PHASE >= N_PHASES SHALL be ignored, with EMERG treated as 0.
- REQ-016: Changes to EMERG_PHASE while in PREEMPT SHALL take effect only after YELLOW and ALL_RED.
- REQ-017: When EMERG and VEH_REQ are active together, EMERG SHALL take priority.

Reset
- REQ-018: Asserting RESET SHALL immediately force the following, regardless of the current state or mid-cycle timing:
  - state ALL_RED
  - timer = ALLRED_T-1
  - ACTIVE_PHASE = N_PHASES-1, so that phase 0 is first in the fallback rotation
  - RED all ones, YELLOW and GREEN all zeros, PREEMPT_ACT=0
- REQ-019: After RESET deasserts, operation SHALL start on the first rising edge.

Verification
- REQ-020: Fixed-time run. Defaults, VEH_REQ=0, EMERG=0, reset released → phases 0,1,2,3,0 served in order. Each phase SHALL show green 20, yellow 4, all-red 2 cycles, for a 26-cycle period per phase.
- REQ-021: Demand skip. VEH_REQ=4'b0100 held → only phase 2 is served. Each green SHALL last the full 20 cycles because no other phase requests, so there is no gap-out.
- REQ-022: Gap-out. Phase 0 green, VEH_REQ=4'b0010 asserted at green cycle 2 → YELLOW[0] SHALL rise after green cycle 6, then phase 1 is served.
- REQ-023: Preemption mid-green. Phase 1 green at cycle 3, EMERG=1, EMERG_PHASE=3 → 4 yellow and 2 all-red cycles, then GREEN[3]=1 and PREEMPT_ACT=1 held for 50 cycles. On EMERG=0, 4 yellow cycles follow, then normal selection.
- REQ-024: Reset mid-yellow. RESET pulsed asynchronously during YELLOW[2] → all lamps red on the same cycle, timer=1. Phase 0 SHALL go green 2 cycles after release.
- REQ-025: Illegal preempt and invariant. With N_PHASES=3, EMERG_PHASE=3 → no preemption occurs. Across all scenarios, the checker SHALL confirm one-hot GREEN|YELLOW and zero conflicting greens.
